// File: rtl/conway_pkg.sv
// Shared definitions for the Conway neighbour-window slice.
//   NB_NW..NB_SE    : bit positions inside the 8-bit neighbour vector
//   window_state_t  : FILL / RUN / FLUSH phases of the window generator
//   popcount8       : live-neighbour count of an 8-bit neighbour vector
package conway_pkg;

  localparam int NB_NW = 0;
  localparam int NB_N  = 1;
  localparam int NB_NE = 2;
  localparam int NB_W  = 3;
  localparam int NB_E  = 4;
  localparam int NB_SW = 5;
  localparam int NB_S  = 6;
  localparam int NB_SE = 7;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } window_state_t;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/conway_neighbor_window_if.sv
// Stream interface between a cell-state source, the neighbour window and
// its consumer.
//   in_valid/in_ready/in_state  : one cell state per accepted beat, raster order
//   out_valid/out_ready         : one emitted cell per handshake
//   out_center/out_neighbors    : cell state and its 8 neighbours
//   out_row/out_col             : position of the emitted cell
//   frame_done                  : pulse with the last cell's handshake
//   out_count                   : live-neighbour count (CONWAY_COUNT_EN only)
// Handshake rule for both channels: a beat transfers on a rising clk edge
// where valid and ready are both high; a source holding valid high keeps
// its payload stable until that edge.
// Optional macro: CONWAY_COUNT_EN adds out_count.
interface conway_neighbor_window_if #(
  parameter int COLS = 16,
  parameter int ROWS = 16
);
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);

  logic          in_valid;
  logic          in_ready;
  logic          in_state;
  logic          out_valid;
  logic          out_ready;
  logic          out_center;
  logic [7:0]    out_neighbors;
  logic [RW-1:0] out_row;
  logic [CW-1:0] out_col;
  logic          frame_done;
`ifdef CONWAY_COUNT_EN
  logic [3:0]    out_count;

  modport slave (
    input  in_valid, in_state, out_ready,
    output in_ready, out_valid, out_center, out_neighbors, out_row, out_col,
           frame_done, out_count
  );
  modport master (
    output in_valid, in_state, out_ready,
    input  in_ready, out_valid, out_center, out_neighbors, out_row, out_col,
           frame_done, out_count
  );
`else
  modport slave (
    input  in_valid, in_state, out_ready,
    output in_ready, out_valid, out_center, out_neighbors, out_row, out_col,
           frame_done
  );
  modport master (
    output in_valid, in_state, out_ready,
    input  in_ready, out_valid, out_center, out_neighbors, out_row, out_col,
           frame_done
  );
`endif
endinterface

// File: rtl/conway_shift_window.sv
// Raster-order window shift register of 2*COLS+3 bits; index 0 holds the
// newest sample. Exposes the centre (index COLS+1) and its 8 raw taps.
// No edge masking happens here.
//   clk, rst  : clock, asynchronous active-high reset (clears the window)
//   shift_en  : shift din in at index 0
//   din       : sample to shift in
//   tap_*     : raw window taps around the centre
module conway_shift_window #(
  parameter int COLS = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic shift_en,
  input  logic din,
  output logic tap_nw,
  output logic tap_n,
  output logic tap_ne,
  output logic tap_w,
  output logic tap_c,
  output logic tap_e,
  output logic tap_sw,
  output logic tap_s,
  output logic tap_se
);
  localparam int W = 2 * COLS + 3;

  logic [W-1:0] win_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_q <= '0;
    end else if (shift_en) begin
      win_q <= {win_q[W-2:0], din};
    end
  end

  assign tap_nw = win_q[2*COLS+2];
  assign tap_n  = win_q[2*COLS+1];
  assign tap_ne = win_q[2*COLS];
  assign tap_w  = win_q[COLS+2];
  assign tap_c  = win_q[COLS+1];
  assign tap_e  = win_q[COLS];
  assign tap_sw = win_q[2];
  assign tap_s  = win_q[1];
  assign tap_se = win_q[0];

endmodule

// File: rtl/conway_neighbor_window.sv
// Streaming 3x3 neighbourhood generator for a ROWS x COLS grid. Takes one
// frame of cell states in raster order and emits, per cell, its state and
// its 8 neighbours (bit order NW,N,NE,W,E,SW,S,SE = 0..7), with cells
// outside the grid reading dead.
//   clk, rst   : clock, asynchronous active-high reset
//   ena        : global advance enable; low freezes all state
//   bus        : stream interface (slave side), see conway_neighbor_window_if
//   state_dbg  : current FILL/RUN/FLUSH phase
// Optional macro: CONWAY_COUNT_EN drives bus.out_count with the popcount of
// the masked neighbours.
module conway_neighbor_window
  import conway_pkg::*;
#(
  parameter int COLS = 16,
  parameter int ROWS = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ena,
  conway_neighbor_window_if.slave   bus,
  output window_state_t             state_dbg
);
  localparam int NCELL = ROWS * COLS;
  localparam int CNT_W = $clog2(NCELL);
  localparam int FL_W  = $clog2(COLS + 1);
  localparam int RW    = $clog2(ROWS);
  localparam int CW    = $clog2(COLS);

  window_state_t  state_q, state_d;
  logic [CNT_W-1:0] in_cnt_q;   // samples accepted this frame
  logic [FL_W-1:0]  fl_cnt_q;   // flush steps taken this frame
  logic [RW-1:0]  row_q;
  logic [CW-1:0]  col_q;
  logic           out_valid_q;

  logic out_free;   // output register may take a new cell this cycle
  logic in_ready_c;
  logic step;
  logic emit;
  logic last_in;    // current step accepts the final sample of the frame
  logic last_fl;    // current step is the final flush step

  logic tap_nw, tap_n, tap_ne, tap_w, tap_c, tap_e, tap_sw, tap_s, tap_se;
  logic [7:0] raw_nb;
  logic [7:0] keep;
  logic [7:0] nb_masked;

  assign out_free = ena & (~out_valid_q | bus.out_ready);
  assign last_in  = (in_cnt_q == CNT_W'(NCELL - 1));
  assign last_fl  = (fl_cnt_q == FL_W'(COLS));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= FILL;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    in_ready_c = 1'b0;
    step       = 1'b0;
    emit       = 1'b0;
    in_ready_c = out_free & (state_q != FLUSH);
    step       = out_free & ((bus.in_valid & in_ready_c) | (state_q == FLUSH));
    emit       = step & (state_q != FILL);
    case (state_q)
      FILL:    if (step && in_cnt_q == CNT_W'(COLS)) state_d = RUN;
      RUN:     if (step && last_in)                  state_d = FLUSH;
      FLUSH:   if (step && last_fl)                  state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_cnt_q <= '0;
      fl_cnt_q <= '0;
    end else if (step) begin
      case (state_q)
        FILL:    in_cnt_q <= in_cnt_q + 1'b1;
        RUN:     in_cnt_q <= last_in ? '0 : in_cnt_q + 1'b1;
        FLUSH:   fl_cnt_q <= last_fl ? '0 : fl_cnt_q + 1'b1;
        default: begin
          in_cnt_q <= '0;
          fl_cnt_q <= '0;
        end
      endcase
    end
  end

  // Position of the emitted cell. The first RUN step of a frame (COLS+1
  // samples already taken) restarts at (0,0); later steps walk raster order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_q <= '0;
      col_q <= '0;
    end else if (emit) begin
      if (state_q == RUN && in_cnt_q == CNT_W'(COLS + 1)) begin
        row_q <= '0;
        col_q <= '0;
      end else if (col_q == CW'(COLS - 1)) begin
        col_q <= '0;
        row_q <= (row_q == RW'(ROWS - 1)) ? '0 : row_q + 1'b1;
      end else begin
        col_q <= col_q + 1'b1;
      end
    end
  end

  // With ena low nothing is consumed, so out_valid must survive out_ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     out_valid_q <= 1'b0;
    else if (emit)               out_valid_q <= 1'b1;
    else if (ena & bus.out_ready) out_valid_q <= 1'b0;
  end

  // FLUSH shifts dead cells in behind the last row.
  conway_shift_window #(.COLS(COLS)) u_window (
    .clk      (clk),
    .rst      (rst),
    .shift_en (step),
    .din      ((state_q == FLUSH) ? 1'b0 : bus.in_state),
    .tap_nw   (tap_nw),
    .tap_n    (tap_n),
    .tap_ne   (tap_ne),
    .tap_w    (tap_w),
    .tap_c    (tap_c),
    .tap_e    (tap_e),
    .tap_sw   (tap_sw),
    .tap_s    (tap_s),
    .tap_se   (tap_se)
  );

  // The window and row/col registers move on the same step, so the masked
  // fields are a function of registered state and hold during stalls. Taps
  // that wrap across a row edge or into another frame are masked here.
  always_comb begin
    raw_nb        = '0;
    raw_nb[NB_NW] = tap_nw;
    raw_nb[NB_N]  = tap_n;
    raw_nb[NB_NE] = tap_ne;
    raw_nb[NB_W]  = tap_w;
    raw_nb[NB_E]  = tap_e;
    raw_nb[NB_SW] = tap_sw;
    raw_nb[NB_S]  = tap_s;
    raw_nb[NB_SE] = tap_se;

    keep = 8'hFF;
    if (row_q == '0) begin
      keep[NB_NW] = 1'b0; keep[NB_N] = 1'b0; keep[NB_NE] = 1'b0;
    end
    if (row_q == RW'(ROWS - 1)) begin
      keep[NB_SW] = 1'b0; keep[NB_S] = 1'b0; keep[NB_SE] = 1'b0;
    end
    if (col_q == '0) begin
      keep[NB_NW] = 1'b0; keep[NB_W] = 1'b0; keep[NB_SW] = 1'b0;
    end
    if (col_q == CW'(COLS - 1)) begin
      keep[NB_NE] = 1'b0; keep[NB_E] = 1'b0; keep[NB_SE] = 1'b0;
    end
    nb_masked = raw_nb & keep;
  end

  assign bus.in_ready      = in_ready_c;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_center    = tap_c;
  assign bus.out_neighbors = nb_masked;
  assign bus.out_row       = row_q;
  assign bus.out_col       = col_q;
  assign bus.frame_done    = ena & out_valid_q & bus.out_ready &
                             (row_q == RW'(ROWS - 1)) & (col_q == CW'(COLS - 1));
`ifdef CONWAY_COUNT_EN
  assign bus.out_count     = popcount8(nb_masked);
`endif
  assign state_dbg         = state_q;

endmodule

// File: doc/conway_neighbor_window.md
Name: conway_neighbor_window

Overview:
- Streaming window generator that sits directly upstream of conway_cell.
- Accepts one frame of cell states in raster order, one bit per accepted beat.
- For every cell it emits the cell's own state plus its 8 neighbour states, packed in the bit order conway_cell consumes on `neighbors`.
- Grid edges are dead (out-of-grid neighbours read 0); frames are delimited by count, not markers.

Parameters:
- COLS, 16, grid width in cells (>=2)
- ROWS, 16, grid height in cells (>=2)

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- ena  input  1  global advance enable; low freezes all state
- in_valid  input  1  upstream offers in_state
- in_ready  output  1  block accepts in_state this cycle
- in_state  input  1  next cell state in raster order
- out_valid  output  1  out_* fields hold a cell
- out_ready  input  1  downstream accepts this cycle
- out_center  output  1  state of cell (out_row, out_col)
- out_neighbors  output  8  neighbour states; ordering under Behaviour
- out_row  output  $clog2(ROWS)  row of the emitted cell
- out_col  output  $clog2(COLS)  column of the emitted cell
- frame_done  output  1  one-cycle pulse with the last cell's output handshake

Behaviour:
- One clock, clk. Reset is asynchronous and active-high on rst.
- Reset values:
  - out_valid=0, out_center=0, out_neighbors=0, out_row=0, out_col=0, frame_done=0.
  - Window shift register cleared, all counters 0, state FILL.
  - rst mid-frame aborts the frame; no partial output follows.
- Neighbour bit order: 0=NW 1=N 2=NE 3=W 4=E 5=SW 6=S 7=SE.
- Window is a shift register of 2*COLS+3 bits; index 0 is the newest sample.
  - Center is at index COLS+1.
  - Taps: NW 2*COLS+2, N 2*COLS+1, NE 2*COLS, W COLS+2, E COLS, SW 2, S 1, SE 0.
- Edge masking (forces the named bits to 0), applied from the center's row/col:
  - row 0 masks NW,N,NE.
  - row ROWS-1 masks SW,S,SE.
  - col 0 masks NW,W,SW.
  - col COLS-1 masks NE,E,SE.
  - Corners apply both masks.
- Advance condition: step = ena & (!out_valid | out_ready) & (in_valid&in_ready | state==FLUSH).
  - All state changes occur only on step, except that out_valid clears when out_ready consumes it and nothing new is stepped.
- FSM states:
  - FILL: in_ready = ena & (!out_valid|out_ready). Shifts in samples without producing output. After COLS+1 samples go to RUN.
  - RUN: each accepted sample shifts the window and registers one output cell (out_valid=1 next cycle). After the ROWS*COLS-th sample go to FLUSH.
  - FLUSH: in_ready=0. Shifts in 0s, one per step, each producing one output. After COLS+1 flush steps, return to FILL with counters cleared.
- Latency: output for cell (r,c) is registered on the cycle the sample for cell r*COLS+c+COLS+1 is accepted, or on the matching flush step. Exactly ROWS*COLS outputs per frame, in raster order.
- Backpressure: while out_valid=1 and out_ready=0, all outputs, the window and the counters hold. in_ready=0 in this condition.
- ena=0: in_ready=0; outputs, window, counters and FSM hold; out_valid is not cleared.
- frame_done=1 for exactly the cycle the cell (ROWS-1, COLS-1) is handshaken (out_valid&out_ready).
- Back-to-back frames: the first sample of the next frame may be accepted on the step after the last flush step.
- Counter wrap: out_col wraps COLS-1→0 and increments out_row; out_row wraps ROWS-1→0 at frame end.

Optional Feature:
- Macro: CONWAY_COUNT_EN.
- Defined: adds output out_count [3:0], the popcount of the masked out_neighbors, registered alongside the other out_* fields. Reset value 0. It lets the downstream skip its own adder tree.
- Undefined: port absent; no popcount logic.

Decomposition:
- conway_pkg holds:
  - localparams for neighbour bit indices (NB_NW..NB_SE).
  - typedef enum logic [1:0] {FILL, RUN, FLUSH} window_state_t.
  - function popcount8.
- One sub-module: conway_shift_window. It owns the parameterised 2*COLS+3-bit shift register, with shift-enable and data-in, and exposes the 9 raw taps. Masking, FSM and handshake stay in the top.

Test Plan:
- COLS=ROWS=4, single live cell at (1,1), out_ready=1 → exactly 16 outputs.
  - (1,1) center=1, neighbors=0.
  - (0,0) neighbors=8'h80.
  - (2,2) neighbors=8'h01.
  - (0,1) neighbors=8'h40.
  - All others consistent; frame_done pulses once.
- All-ones 4x4 frame → corner neighbors: (0,0)=8'hD0, (0,3)=8'h68, (3,0)=8'h16, (3,3)=8'h0B. Interior (1,1)=8'hFF. Edge (0,1)=8'hF8.
- Random out_ready (50%) and in_valid gaps on a random 4x4 frame → output sequence identical to the stall-free run; no drops or duplicates; fields stable while stalled.
- ena held low 5 cycles mid-RUN → in_ready=0, out_* unchanged; resume yields a correct frame.
- rst pulsed asynchronously after 7 samples → immediate out_valid=0, state FILL; next full frame is correct.
- Two back-to-back frames with no idle → 32 outputs. Second frame has no leakage from the first: row 0 of frame 2 masks N bits even though frame 1's data is still in the window.
